fp_result_buffer: RTL and testbench

Result-side buffer sitting directly downstream of the pipelined FP multiplier. The multiplier has no backpressure, so this block captures every `valid_data_out` beat with its flags into a DEPTH-entry FIFO and presents results to the consumer over valid/ready. It returns issue credits to the upstream launcher so that the in-flight operations plus buffered results can never exceed DEPTH. It also maintains the architectural sticky exception-flag register (fflags).

---
 rtl/fp_result_buffer.sv | 146 ++++++++++++++
 tb/tb_fp_result_buffer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp_result_buffer.sv
// Result buffer behind the FP multiplier. It captures every result beat into a FWFT FIFO, returns issue credits and keeps the sticky fflags.
// Latency: a captured beat is visible 1 cycle later, and pops take effect at the edge.
// Backpressure: the consumer uses out_valid/out_ready; upstream is throttled by issue_credit, and beats that arrive when the FIFO is full are dropped and set overrun.

module sync_fifo #(
  parameter int W     = 36,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  wr_dat,
  input  logic          pop,
  output logic [W-1:0]  rd_dat,
  output logic [AW:0]   count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two; the caller never pushes into a full FIFO without a pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_dat;
  end

  assign rd_dat = mem[rd_ptr];

endmodule

module fp_result_buffer #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          issue_valid,
  output logic          issue_credit,
  input  logic          res_valid_in,
  input  logic [31:0]   res_data_in,
  input  logic [3:0]    res_flags_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_data,
  output logic [3:0]    out_flags,
  output logic [4:0]    fflags,
  input  logic          fflags_clear,
  output logic [AW:0]   occupancy,
  output logic          overrun
);

  typedef struct packed {
    logic [3:0]  flags;
    logic [31:0] data;
  } res_t;

  localparam logic [AW:0]   FULL  = (AW+1)'(DEPTH);
  localparam logic [AW+1:0] LIMIT = (AW+2)'(DEPTH);

  logic [AW:0]   count;
  logic [AW:0]   inflight;
  logic [AW+1:0] committed;
  logic          issue_fire;
  logic          push;
  logic          pop;
  logic          drop;
  res_t          wr_ent;
  res_t          head;
  logic [4:0]    flag_map;
  logic [4:0]    fflags_q;
  logic          overrun_q;

  assign wr_ent = '{flags: res_flags_in, data: res_data_in};

  sync_fifo #(.W($bits(res_t)), .DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .wr_dat (wr_ent),
    .pop    (pop),
    .rd_dat (head),
    .count  (count)
  );

  // The credit is computed from registers only, so a pop cannot raise it within the same cycle.
  assign committed    = {1'b0, count} + {1'b0, inflight};
  assign issue_credit = committed < LIMIT;
  assign issue_fire   = issue_valid & issue_credit;

  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign push      = res_valid_in & ((count < FULL) | pop);
  assign drop      = res_valid_in & ~push;

  assign out_data  = head.data;
  assign out_flags = head.flags;
  assign occupancy = count;

  // Stray results with nothing in flight leave the count at zero instead of wrapping it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      case ({issue_fire, res_valid_in})
        2'b10:   inflight <= inflight + (AW+1)'(1);
        2'b01:   inflight <= (inflight != '0) ? inflight - (AW+1)'(1) : inflight;
        default: inflight <= inflight;
      endcase
    end
  end

  // Map {NV, OF, UF, NX} into {NV, DZ, OF, UF, NX}. DZ cannot occur in a multiply.
  assign flag_map = res_valid_in ?
      {res_flags_in[3], 1'b0, res_flags_in[2], res_flags_in[1], res_flags_in[0]} : 5'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fflags_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      fflags_q  <= (fflags_clear ? 5'b0 : fflags_q) | flag_map;
      overrun_q <= overrun_q | drop;
    end
  end

  assign fflags  = fflags_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_fp_result_buffer.sv
// Directed and randomized bench for fp_result_buffer, checked against a queue-based reference model.
module tb_fp_result_buffer;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue_valid = 1'b0;
  logic        issue_credit;
  logic        res_valid_in = 1'b0;
  logic [31:0] res_data_in = '0;
  logic [3:0]  res_flags_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [3:0]  out_flags;
  logic [4:0]  fflags;
  logic        fflags_clear = 1'b0;
  logic [3:0]  occupancy;
  logic        overrun;

  always #5 clk = ~clk;

  fp_result_buffer #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .issue_valid  (issue_valid),
    .issue_credit (issue_credit),
    .res_valid_in (res_valid_in),
    .res_data_in  (res_data_in),
    .res_flags_in (res_flags_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_flags    (out_flags),
    .fflags       (fflags),
    .fflags_clear (fflags_clear),
    .occupancy    (occupancy),
    .overrun      (overrun)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [35:0] q[$];
  int          m_infl;
  logic        m_ovr;
  logic [4:0]  m_ff;
  int          popped;
  int          max_occ;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_credit();
    return (q.size() + m_infl) < DEPTH;
  endfunction

  task automatic model_reset();
    q.delete();
    m_infl = 0;
    m_ovr  = 1'b0;
    m_ff   = '0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_vld"},    32'(out_valid),    32'(q.size() != 0));
    chk({tag, "_occ"},    32'(occupancy),    32'(q.size()));
    chk({tag, "_credit"}, 32'(issue_credit), 32'(model_credit()));
    chk({tag, "_fflags"}, 32'(fflags),       32'(m_ff));
    chk({tag, "_ovr"},    32'(overrun),      32'(m_ovr));
    if (q.size() != 0) begin
      chk({tag, "_data"},  out_data,          q[0][31:0]);
      chk({tag, "_flags"}, 32'(out_flags),    32'(q[0][35:32]));
    end
    if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
  endtask

  task automatic step(input string tag, input logic iv, input logic rv, input logic [31:0] d,
                      input logic [3:0] fl, input logic rdy, input logic clr);
    logic fire, pop, acc;
    issue_valid  = iv;
    res_valid_in = rv;
    res_data_in  = d;
    res_flags_in = fl;
    out_ready    = rdy;
    fflags_clear = clr;
    fire = iv && model_credit();
    pop  = (q.size() != 0) && rdy;
    acc  = rv && ((q.size() < DEPTH) || pop);
    @(posedge clk);
    #1;
    if (pop) begin
      void'(q.pop_front());
      popped++;
    end
    if (acc) q.push_back({fl, d});
    if (rv && !acc) m_ovr = 1'b1;
    if (fire) m_infl++;
    if (rv && m_infl > 0) m_infl--;
    m_ff = (clr ? 5'b0 : m_ff) | (rv ? {fl[3], 1'b0, fl[2], fl[1], fl[0]} : 5'b0);
    check_all(tag);
  endtask

  task automatic do_reset();
    issue_valid = 0; res_valid_in = 0; out_ready = 0; fflags_clear = 0;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int pend[$];
    int issued;
    logic fire_b, rv_b, iv_b;

    model_reset();
    popped  = 0;
    max_occ = 0;
    do_reset();

    // Single beat: 3.0 * 2.0
    step("iss", 1, 0, 0, 0, 0, 0);
    step("beat", 0, 1, 32'h40C00000, 4'h0, 0, 0);
    chk("single_vld", 32'(out_valid), 32'd1);
    chk("single_data", out_data, 32'h40C00000);
    chk("single_occ", 32'(occupancy), 32'd1);
    step("pop", 0, 0, 0, 0, 1, 0);
    chk("single_occ0", 32'(occupancy), 32'd0);
    chk("single_ff", 32'(fflags), 32'd0);

    // Credit limit, including an ignored issue while credit is zero
    for (int i = 0; i < DEPTH; i++) step("ci", 1, 0, 0, 0, 0, 0);
    chk("credit_zero", 32'(issue_credit), 32'd0);
    step("viol", 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) step("cr", 0, 1, $urandom, 4'h0, 0, 0);
    chk("credit_full_occ", 32'(occupancy), 32'd8);
    chk("credit_full_cr", 32'(issue_credit), 32'd0);
    out_ready = 1'b1;
    #1;
    chk("credit_no_comb", 32'(issue_credit), 32'd0);
    step("cpop", 0, 0, 0, 0, 1, 0);
    chk("credit_back", 32'(issue_credit), 32'd1);

    // Full FIFO with push+pop, then a dropped beat
    step("fi", 1, 0, 0, 0, 0, 0);
    step("fr", 0, 1, $urandom, 4'h0, 0, 0);
    chk("full_occ", 32'(occupancy), 32'd8);
    step("full_pp", 0, 1, $urandom, 4'h0, 1, 0);
    chk("full_pp_occ", 32'(occupancy), 32'd8);
    chk("full_pp_ovr", 32'(overrun), 32'd0);
    step("full_drop", 0, 1, 32'hDEADBEEF, 4'h0, 0, 0);
    chk("drop_ovr", 32'(overrun), 32'd1);
    chk("drop_occ", 32'(occupancy), 32'd8);
    for (int i = 0; i < DEPTH; i++) step("drain", 0, 0, 0, 0, 1, 0);
    chk("drain_occ", 32'(occupancy), 32'd0);

    // Sticky flags
    do_reset();
    step("f1", 0, 1, 32'h7FC00000, 4'b1000, 0, 0);
    chk("ff_nv", 32'(fflags), 32'b10000);
    step("f2", 0, 1, $urandom, 4'b0101, 0, 0);
    chk("ff_nv_of_nx", 32'(fflags), 32'b10101);
    step("f3", 0, 1, $urandom, 4'b0001, 0, 1);
    chk("ff_clear", 32'(fflags), 32'b00001);
    for (int i = 0; i < 3; i++) step("fdrain", 0, 0, 0, 0, 1, 0);

    // Wrap-around stream of 20 results with out_ready toggling
    popped  = 0;
    max_occ = 0;
    issued  = 0;
    for (int c = 0; c < 400; c++) begin
      if (issued == 20 && pend.size() == 0 && q.size() == 0) break;
      iv_b   = (issued < 20) && model_credit();
      fire_b = iv_b;
      rv_b   = (pend.size() > 0) && (pend[0] <= c);
      if (rv_b) void'(pend.pop_front());
      if (fire_b) begin
        pend.push_back(c + 3);
        issued++;
      end
      step("wrap", iv_b, rv_b, $urandom, 4'($urandom_range(0, 15)), (c % 2) == 0, 0);
    end
    chk("wrap_popped", 32'(popped), 32'd20);
    chk("wrap_maxocc", 32'(max_occ <= DEPTH), 32'd1);
    chk("wrap_occ0", 32'(occupancy), 32'd0);
    chk("wrap_credit", 32'(issue_credit), 32'd1);
    chk("wrap_ovr", 32'(overrun), 32'd0);

    // Random soak, including stray and dropped beats and clears
    for (int i = 0; i < 150; i++)
      step("rand", 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), $urandom,
           4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));

    // Asynchronous reset in mid-stream
    do_reset();
    for (int i = 0; i < DEPTH; i++) step("mi", 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step("mr", 0, 1, $urandom, 4'h1, 0, 0);
    chk("mid_occ5", 32'(occupancy), 32'd5);
    chk("mid_credit0", 32'(issue_credit), 32'd0);
    issue_valid = 0; res_valid_in = 0; out_ready = 0; fflags_clear = 0;
    #2;
    rst = 1'b1;
    #1;
    chk("async_occ", 32'(occupancy), 32'd0);
    chk("async_credit", 32'(issue_credit), 32'd1);
    chk("async_vld", 32'(out_valid), 32'd0);
    chk("async_ff", 32'(fflags), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step("post", 0, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
